// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch front-end (fetch_fifo, fetch_queue).
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = '0;

  typedef enum logic {
    FM_IMEM = 1'b0,
    FM_EXT  = 1'b1
  } fetch_mode_e;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with push, pop, synchronous clear and occupancy.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  output fetch_entry_t  head,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign count   = count_q;

  // Pointers rely on DEPTH being a power of two to wrap for free.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= fetch_entry_t'{instr: NOP_INSTR, pc: '0};
      end
    end else if (do_push && !clear) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Fetch front-end: PC generator, single-outstanding imem fetch, external instruction
// input and a decode-facing instruction queue. Optional perf counters: FETCH_PERF_EN.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter int              IMEM_AW  = 12,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       instr_mode,
  input  logic                       ext_valid,
  input  logic [31:0]                ext_instr,
  output logic                       ext_ready,
  output logic                       imem_req,
  output logic [IMEM_AW-1:0]         imem_addr,
  input  logic [31:0]                imem_rdata,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       d_valid,
  input  logic                       d_ready,
  output logic [31:0]                d_instr,
  output logic [XLEN-1:0]            d_pc,
  output logic [XLEN-1:0]            d_pc_plus4,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [31:0]                perf_redirects,
  output logic [31:0]                perf_bubbles
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // ext_ready and d_valid never depend on the partner's valid/ready in the same cycle.

  fetch_mode_e     mode_q;
  logic            inflight;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;
  logic            switch_pending;
  logic            mem_push;
  logic            ext_push;
  logic            push;
  logic            pop;
  logic            empty;
  logic            full;
  fetch_entry_t    push_data;
  fetch_entry_t    head;

  // A pending mode change stops new fetches/accepts so the queue can drain.
  assign switch_pending = ((mode_q == FM_EXT) != instr_mode);

  assign imem_req  = !reset && (mode_q == FM_IMEM) && !switch_pending && !redirect_valid
                     && !inflight && ((int'(count) + int'(inflight)) < DEPTH);
  assign imem_addr = fetch_pc[IMEM_AW-1:0];
  assign ext_ready = !reset && (mode_q == FM_EXT) && !switch_pending && !redirect_valid && !full;

  assign mem_push  = inflight && !redirect_valid && !reset;
  assign ext_push  = ext_valid && ext_ready;
  assign push      = mem_push || ext_push;
  assign push_data = mem_push ? fetch_entry_t'{instr: imem_rdata, pc: req_pc}
                              : fetch_entry_t'{instr: ext_instr, pc: fetch_pc};
  assign pop       = d_valid && d_ready && !redirect_valid;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  assign d_valid    = !empty;
  assign d_instr    = empty ? '0 : head.instr;
  assign d_pc       = empty ? '0 : head.pc;
  assign d_pc_plus4 = empty ? '0 : head.pc + XLEN'(4);

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
      mode_q   <= FM_IMEM;
    end else begin
      if (redirect_valid) begin
        fetch_pc <= redirect_pc & ~XLEN'(3);
        inflight <= 1'b0;
      end else if (imem_req) begin
        inflight <= 1'b1;
        req_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + XLEN'(4);
      end else begin
        if (ext_push) fetch_pc <= fetch_pc + XLEN'(4);
        inflight <= 1'b0;
      end
      if ((count == '0) && !inflight && !push) begin
        mode_q <= instr_mode ? FM_EXT : FM_IMEM;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] redirect_cnt;
  logic [31:0] bubble_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_cnt <= '0;
      bubble_cnt   <= '0;
    end else begin
      if (redirect_valid && (redirect_cnt != '1)) redirect_cnt <= redirect_cnt + 32'd1;
      if (d_ready && !d_valid && (bubble_cnt != '1)) bubble_cnt <= bubble_cnt + 32'd1;
    end
  end

  assign perf_redirects = redirect_cnt;
  assign perf_bubbles   = bubble_cnt;
`else
  assign perf_redirects = '0;
  assign perf_bubbles   = '0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: imem fetch, stall/backpressure, redirect, ext mode,
// mode switch and perf counters, with hand-computed expected values.
module tb_fetch_queue;

  logic        clk;
  logic        reset;
  logic        instr_mode;
  logic        ext_valid;
  logic [31:0] ext_instr;
  logic        ext_ready;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        d_valid;
  logic        d_ready;
  logic [31:0] d_instr;
  logic [31:0] d_pc;
  logic [31:0] d_pc_plus4;
  logic [2:0]  count;
  logic [31:0] perf_redirects;
  logic [31:0] perf_bubbles;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_perf_r;
  logic [31:0] exp_perf_b;

  fetch_queue dut (
    .clk            (clk),
    .reset          (reset),
    .instr_mode     (instr_mode),
    .ext_valid      (ext_valid),
    .ext_instr      (ext_instr),
    .ext_ready      (ext_ready),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .d_valid        (d_valid),
    .d_ready        (d_ready),
    .d_instr        (d_instr),
    .d_pc           (d_pc),
    .d_pc_plus4     (d_pc_plus4),
    .count          (count),
    .perf_redirects (perf_redirects),
    .perf_bubbles   (perf_bubbles)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: word = 0xA0000 concatenated with the byte address.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= {20'hA0000, imem_addr};
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; instr_mode = 1'b0; ext_valid = 1'b0; ext_instr = '0;
    redirect_valid = 1'b0; redirect_pc = '0; d_ready = 1'b0; imem_rdata = '0;
    cyc(); cyc(); #1;
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_ext_ready", {31'd0, ext_ready}, 32'd0);
    chk("rst_d_valid", {31'd0, d_valid}, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_d_instr", d_instr, 32'd0);
    chk("rst_d_pc", d_pc, 32'd0);
    chk("rst_d_pc_plus4", d_pc_plus4, 32'd0);
    chk("rst_perf_r", perf_redirects, 32'd0);
    chk("rst_perf_b", perf_bubbles, 32'd0);

    // Basic imem fetch, d_ready=1
    reset = 1'b0; d_ready = 1'b1; #1;
    chk("t1_c0_req", {31'd0, imem_req}, 32'd1);
    chk("t1_c0_addr", {20'd0, imem_addr}, 32'h000);
    cyc(); #1;
    chk("t1_c1_req", {31'd0, imem_req}, 32'd0);
    chk("t1_c1_valid", {31'd0, d_valid}, 32'd0);
    cyc(); #1;
    chk("t1_c2_valid", {31'd0, d_valid}, 32'd1);
    chk("t1_c2_pc", d_pc, 32'h0);
    chk("t1_c2_pc4", d_pc_plus4, 32'h4);
    chk("t1_c2_instr", d_instr, 32'hA000_0000);
    chk("t1_c2_addr", {20'd0, imem_addr}, 32'h004);
    cyc(); #1;
    chk("t1_c3_valid", {31'd0, d_valid}, 32'd0);
    cyc(); #1;
    chk("t1_c4_pc", d_pc, 32'h4);
    cyc(); cyc(); #1;
    chk("t1_c6_pc", d_pc, 32'h8);
    chk("t1_c6_pc4", d_pc_plus4, 32'hC);

    // Reset mid-flight, then fill with d_ready=0
    reset = 1'b1; d_ready = 1'b0;
    cyc(); #1;
    chk("t2_rst_count", {29'd0, count}, 32'd0);
    chk("t2_rst_valid", {31'd0, d_valid}, 32'd0);
    reset = 1'b0;
    repeat (8) cyc();
    #1;
    chk("t2_full_count", {29'd0, count}, 32'd4);
    chk("t2_full_req", {31'd0, imem_req}, 32'd0);
    cyc(); cyc(); #1;
    chk("t2_stall_count", {29'd0, count}, 32'd4);
    chk("t2_stall_req", {31'd0, imem_req}, 32'd0);
    d_ready = 1'b1; #1;
    chk("t2_x0_pc", d_pc, 32'h0);
    chk("t2_x0_req", {31'd0, imem_req}, 32'd0);
    cyc(); #1;
    chk("t2_x1_pc", d_pc, 32'h4);
    chk("t2_x1_req", {31'd0, imem_req}, 32'd1);
    chk("t2_x1_addr", {20'd0, imem_addr}, 32'h010);
    cyc(); #1;
    chk("t2_x2_pc", d_pc, 32'h8);
    cyc(); #1;
    chk("t2_x3_pc", d_pc, 32'hC);
    cyc(); #1;
    chk("t2_x4_pc", d_pc, 32'h10);
    chk("t2_x4_instr", d_instr, 32'hA000_0010);

    // Redirect with count=3 and a request in flight
    reset = 1'b1; d_ready = 1'b0;
    cyc(); reset = 1'b0;
    repeat (7) cyc();
    #1;
    chk("t3_pre_count", {29'd0, count}, 32'd3);
    redirect_valid = 1'b1; redirect_pc = 32'h103; #1;
    chk("t3_redir_req", {31'd0, imem_req}, 32'd0);
    cyc(); redirect_valid = 1'b0; #1;
    chk("t3_post_count", {29'd0, count}, 32'd0);
    chk("t3_post_valid", {31'd0, d_valid}, 32'd0);
    chk("t3_post_req", {31'd0, imem_req}, 32'd1);
    chk("t3_post_addr", {20'd0, imem_addr}, 32'h100);
    cyc(); #1;
    chk("t3_c9_valid", {31'd0, d_valid}, 32'd0);
    cyc(); #1;
    chk("t3_c10_valid", {31'd0, d_valid}, 32'd1);
    chk("t3_c10_pc", d_pc, 32'h100);
    chk("t3_c10_instr", d_instr, 32'hA000_0100);

    // External mode
    reset = 1'b1; d_ready = 1'b0; instr_mode = 1'b1;
    cyc(); reset = 1'b0; #1;
    chk("t4_c0_req", {31'd0, imem_req}, 32'd0);
    chk("t4_c0_ready", {31'd0, ext_ready}, 32'd0);
    cyc(); redirect_valid = 1'b1; redirect_pc = 32'h20;
    ext_valid = 1'b1; ext_instr = 32'h0050_0093; #1;
    chk("t4_redir_ready", {31'd0, ext_ready}, 32'd0);
    cyc(); redirect_valid = 1'b0; #1;
    chk("t4_c2_ready", {31'd0, ext_ready}, 32'd1);
    cyc(); #1;
    chk("t4_c3_valid", {31'd0, d_valid}, 32'd1);
    chk("t4_c3_pc", d_pc, 32'h20);
    chk("t4_c3_instr", d_instr, 32'h0050_0093);
    chk("t4_c3_pc4", d_pc_plus4, 32'h24);
    cyc(); cyc(); cyc(); #1;
    chk("t4_full_count", {29'd0, count}, 32'd4);
    chk("t4_full_ready", {31'd0, ext_ready}, 32'd0);
    chk("t4_full_req", {31'd0, imem_req}, 32'd0);

    // Mode switch held off until drained
    ext_valid = 1'b0; d_ready = 1'b1;
    cyc(); cyc(); d_ready = 1'b0; instr_mode = 1'b0; #1;
    chk("t5_c8_count", {29'd0, count}, 32'd2);
    chk("t5_c8_ready", {31'd0, ext_ready}, 32'd0);
    chk("t5_c8_req", {31'd0, imem_req}, 32'd0);
    cyc(); #1;
    chk("t5_c9_count", {29'd0, count}, 32'd2);
    chk("t5_c9_pc", d_pc, 32'h28);
    chk("t5_c9_req", {31'd0, imem_req}, 32'd0);
    d_ready = 1'b1;
    cyc(); #1;
    chk("t5_c10_pc", d_pc, 32'h2C);
    chk("t5_c10_req", {31'd0, imem_req}, 32'd0);
    cyc(); #1;
    chk("t5_c11_count", {29'd0, count}, 32'd0);
    chk("t5_c11_req", {31'd0, imem_req}, 32'd0);
    cyc(); #1;
    chk("t5_c12_req", {31'd0, imem_req}, 32'd1);
    chk("t5_c12_addr", {20'd0, imem_addr}, 32'h030);
    cyc(); cyc(); #1;
    chk("t5_c14_pc", d_pc, 32'h30);
    chk("t5_c14_instr", d_instr, 32'hA000_0030);

    // Perf counters: 3 redirect cycles, 5 starved cycles
    reset = 1'b1; d_ready = 1'b0; instr_mode = 1'b1; ext_valid = 1'b0;
    cyc(); reset = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    cyc(); cyc(); cyc();
    redirect_valid = 1'b0; d_ready = 1'b1;
    repeat (5) cyc();
    d_ready = 1'b0; #1;
`ifdef FETCH_PERF_EN
    exp_perf_r = 32'd3;
    exp_perf_b = 32'd5;
`else
    exp_perf_r = 32'd0;
    exp_perf_b = 32'd0;
`endif
    chk("t6_perf_redirects", perf_redirects, exp_perf_r);
    chk("t6_perf_bubbles", perf_bubbles, exp_perf_b);
    chk("t6_valid", {31'd0, d_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Parametrised fetch front-end for the pipelined RV32 core. It replaces the bare PC register and instruction-select mux with a PC generator and an instruction queue of DEPTH entries. The queue decouples instruction memory, or external UVM stimulus, from the decode stage through a valid/ready handshake. EXE-stage redirects (taken branch or jump) flush the queue and restart fetch at the target.

Parameters:
XLEN, 32, PC width in bits
DEPTH, 4, queue entries (power of two, ≥2)
IMEM_AW, 12, instruction memory byte-address width
RESET_PC, 32'h0000_0000, PC after reset

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
instr_mode  in  1  0: fetch from imem; 1: accept ext_instr
ext_valid  in  1  external instruction valid
ext_instr  in  32  external instruction word
ext_ready  out  1  queue accepts ext_instr this cycle
imem_req  out  1  fetch request this cycle
imem_addr  out  IMEM_AW  byte address = fetch_pc[IMEM_AW-1:0]
imem_rdata  in  32  instruction word, valid the cycle after imem_req
redirect_valid  in  1  PCSrc_E-style redirect
redirect_pc  in  XLEN  redirect target
d_valid  out  1  queue head valid
d_ready  in  1  decode accepts head (low = stall_D)
d_instr  out  32  head instruction
d_pc  out  XLEN  head PC
d_pc_plus4  out  XLEN  head PC + 4, modulo 2^XLEN
count  out  $clog2(DEPTH+1)  queue occupancy
perf_redirects  out  32  redirect counter (see Optional Feature)
perf_bubbles  out  32  starvation counter (see Optional Feature)

Behaviour:
- Reset: fetch_pc=RESET_PC, queue empty, inflight=0, mode_q=0, count=0, d_valid=0, imem_req=0, ext_ready=0, d_instr/d_pc/d_pc_plus4=0, perf counters=0.
- Pop: d_valid && d_ready. d_* are driven directly from the head storage, with no added latency.
- Memory mode (mode_q=0):
  - imem_req = !reset && !redirect_valid && (count+inflight < DEPTH). A same-cycle pop is not credited.
  - On a request: inflight<=1, fetch_pc<=fetch_pc+4.
  - In the cycle after a request: push {imem_rdata, pc of that request}, unless the response is killed.
  - Latency: request in cycle t, d_valid in cycle t+2. At most one request in flight.
- External mode (mode_q=1):
  - imem_req=0. ext_ready = !redirect_valid && count<DEPTH.
  - ext_valid && ext_ready pushes {ext_instr, fetch_pc}, and fetch_pc<=fetch_pc+4.
- Mode switch: mode_q<=instr_mode only in a cycle with count==0 && inflight==0 && no push. Otherwise the change is held off until the queue drains.
- Redirect (highest priority):
  - Next cycle: queue empty and fetch_pc = {redirect_pc[XLEN-1:2], 2'b00}.
  - Any in-flight response is killed (inflight<=0, no push).
  - A pop or push in the same cycle is discarded; d_valid=0 the following cycle.
- Simultaneous push and pop: count unchanged. Push into a full queue cannot occur by construction; pop from an empty queue is ignored.
- PC arithmetic wraps modulo 2^XLEN; pointers wrap modulo DEPTH.
- Reset asserted mid-operation: state returns to reset values on that edge, and the in-flight response is dropped.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined:
  - perf_redirects increments on each redirect_valid cycle.
  - perf_bubbles increments on each cycle with d_ready && !d_valid && !reset.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- When undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Package fetch_pkg holds:
  - fetch_entry_t struct {logic [31:0] instr; logic [XLEN-1:0] pc;}
  - NOP_INSTR = 32'h0000_0013
  - default RESET_PC
  - fetch_mode_e {FM_IMEM, FM_EXT}
- One sub-module, fetch_fifo: synchronous FIFO of fetch_entry_t with push, pop and synchronous clear, exposing count, empty and full.

Test Plan:
- Reset release, imem mode, d_ready=1, imem returns addr-based words: imem_req in cycle 0 at addr 0x000; d_valid in cycle 2 with d_pc=0x0, d_pc_plus4=0x4; thereafter one instruction every 2 cycles, PCs 0x4, 0x8.
- Hold d_ready=0 with DEPTH=4: count reaches 4 and imem_req stays low. Raise d_ready: pops of PCs 0x0–0xC in order, then fetch resumes at 0x10.
- Redirect to 0x103 while count=3 and a request is in flight: next cycle count=0 and d_valid=0; the next imem_addr is 0x100; the stale response is never seen at d_*.
- instr_mode=1, ext_valid=1 with 0x00500093 after fetch_pc=0x20: entry pushed with d_pc=0x20. With count=DEPTH, ext_ready=0; with redirect_valid=1, ext_ready=0.
- Toggle instr_mode while count=2: mode_q is unchanged until the queue drains, then switches; no entry is lost or duplicated.
- FETCH_PERF_EN defined: 3 redirects and 5 starved cycles give perf_redirects=3, perf_bubbles=5. With the macro undefined, both read 0.
